// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 scan-code-set-2 key decoder:
//               prefix and discard byte values, decoder states, event record.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Prefix bytes that open a multi-byte sequence
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Protocol/status bytes ignored by the decoder in IDLE
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;

    // Bytes following E1 before the Pause event is considered complete
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        PAUSE   = 3'd4
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_ERR0)   || (b == PS2_ERR1) || (b == PS2_BAT_OK) ||
               (b == PS2_ACK)    || (b == PS2_RESEND) || (b == PS2_ECHO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_evt_fifo
// Description : Show-ahead FIFO. Head word is presented combinationally while
//               non-empty; a push into a full FIFO is dropped unless a pop
//               frees a slot in the same cycle. No empty-FIFO bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign count   = cnt;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since reads are masked while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : Turns validated scan-code-set-2 bytes into key events
//               (E0/F0/E1 prefixes resolved), optionally drops typematic
//               repeats, and queues events for a ready/valid consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int FILTER_REPEAT = 1,
    parameter int TIMEOUT       = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [7:0]              evt_code,
    output logic                    evt_ext,
    output logic                    evt_brk,
    output logic [$clog2(DEPTH):0]  evt_count,
    output logic                    ovf,
    input  logic                    clr_ovf
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
    localparam logic          FILT_EN   = (FILTER_REPEAT != 0);

    dec_state_t     state;
    dec_state_t     state_nxt;
    dec_state_t     cur;
    logic [2:0]     skip;
    logic [2:0]     skip_nxt;
    logic [TW-1:0]  tmo_cnt;
    logic           timed_out;

    logic           dec_fire;
    ps2_evt_t       dec_evt;
    logic           dec_pause;

    logic           held_valid;
    logic [8:0]     held;
    logic           held_match;
    logic           suppress;

    logic           push_valid;
    ps2_evt_t       push_evt;
    ps2_evt_t       head_evt;
    logic           fifo_empty;
    logic           fifo_drop;

    // A partial sequence that has waited TIMEOUT cycles is abandoned; a byte
    // landing on that same cycle is decoded as if the FSM were already IDLE.
    assign timed_out = (state != IDLE) && (tmo_cnt == TMO_LIMIT);

    // Idle-cycle counter for partial sequences
    always_ff @(posedge clk) begin
        if (rst || byte_valid || (state == IDLE) || timed_out) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Decoder state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            skip  <= '0;
        end else begin
            state <= state_nxt;
            skip  <= skip_nxt;
        end
    end

    // Decoder next-state and event generation
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip;
        dec_fire  = 1'b0;
        dec_evt   = '0;
        dec_pause = 1'b0;
        cur       = timed_out ? IDLE : state;
        if (timed_out) begin
            state_nxt = IDLE;
        end
        if (byte_valid) begin
            case (cur)
                IDLE: begin
                    if (byte_data == PS2_EXT) begin
                        state_nxt = EXT;
                    end else if (byte_data == PS2_BRK) begin
                        state_nxt = BRK;
                    end else if (byte_data == PS2_PAUSE) begin
                        state_nxt = PAUSE;
                        skip_nxt  = PS2_PAUSE_SKIP;
                    end else if (!is_discard(byte_data)) begin
                        dec_fire = 1'b1;
                        dec_evt  = '{ext: 1'b0, brk: 1'b0, code: byte_data};
                    end
                end
                EXT: begin
                    if (byte_data == PS2_BRK) begin
                        state_nxt = EXT_BRK;
                    end else begin
                        dec_fire  = 1'b1;
                        dec_evt   = '{ext: 1'b1, brk: 1'b0, code: byte_data};
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    dec_fire  = 1'b1;
                    dec_evt   = '{ext: 1'b0, brk: 1'b1, code: byte_data};
                    state_nxt = IDLE;
                end
                EXT_BRK: begin
                    dec_fire  = 1'b1;
                    dec_evt   = '{ext: 1'b1, brk: 1'b1, code: byte_data};
                    state_nxt = IDLE;
                end
                PAUSE: begin
                    // Pause body content is never inspected, only counted
                    if (skip == 3'd1) begin
                        dec_fire  = 1'b1;
                        dec_pause = 1'b1;
                        dec_evt   = '{ext: 1'b0, brk: 1'b0, code: PS2_PAUSE};
                        state_nxt = IDLE;
                        skip_nxt  = '0;
                    end else begin
                        skip_nxt = skip - 3'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign held_match = held_valid && (held == {dec_evt.ext, dec_evt.code});
    assign suppress   = FILT_EN && !dec_pause && !dec_evt.brk && held_match;

    // Repeat filter, held-key tracking and the registered push stage
    always_ff @(posedge clk) begin
        if (rst) begin
            push_valid <= 1'b0;
            push_evt   <= '0;
            held_valid <= 1'b0;
            held       <= '0;
        end else begin
            push_valid <= dec_fire && !suppress;
            push_evt   <= dec_evt;
            if (dec_fire && !dec_pause) begin
                if (dec_evt.brk) begin
                    if (held_match) begin
                        held_valid <= 1'b0;
                    end
                end else if (!held_match) begin
                    held_valid <= 1'b1;
                    held       <= {dec_evt.ext, dec_evt.code};
                end
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(ps2_evt_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_valid),
        .push_data (push_evt),
        .pop       (evt_ready),
        .head      (head_evt),
        .empty     (fifo_empty),
        .count     (evt_count),
        .drop      (fifo_drop)
    );

    // Sticky overflow flag; a drop wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (fifo_drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    assign evt_valid = !fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_ext   = head_evt.ext;
    assign evt_brk   = head_evt.brk;

endmodule
`default_nettype wire
